systolic_feed_ctrl: RTL and testbench
=====================================

// Module: systolic_feed_ctrl
// PURPOSE
//  Pop scheduler for the per-row input FIFOs of the ROWS-by-ROWS PE array. On START it pops
//  LEN operands per row with a diagonal skew: row r starts r cycles after row 0. If any row that
//  is due to pop is empty, every row stalls together so the wavefront stays aligned.
//  Sits between the operand loader that fills the FIFOs and the FIFO POPE pins.
// PARAMETERS
//  ROWS       32  number of row FIFOs / PE rows
//  ROWS_LOG2  5   log2(ROWS)
//  LEN_W      8   width of LEN; a tile is 0..2^LEN_W-1 operands per row
//  SCNT_W     16  width of STALL_CNT
// PORTS
//  CLK        in   1          clock, rising edge
//  RSTn       in   1          asynchronous reset, active-low
//  START      in   1          start pulse; sampled only in IDLE
//  LEN        in   LEN_W      operands per row; sampled with START
//  ABORT      in   1          cancel the current tile
//  FIFO_EMPTY in   ROWS       IS_EMPTY from each row FIFO (bit r = row r)
//  POPE       out  ROWS       pop enable to each row FIFO; doubles as the row-valid strobe to the PEs
//  BUSY       out  1          high while a tile is in progress
//  DONE       out  1          one-cycle pulse when a tile completes
//  STALL_CNT  out  SCNT_W     number of stall cycles in the last or current tile
// BEHAVIOUR
//  Reset: state=IDLE, t=0, len_q=0, BUSY=0, DONE=0, STALL_CNT=0, POPE=0 (combinational from state).
//  FSM states
//   IDLE: START=1, LEN>0  -> RUN, latch len_q=LEN, t=0.
//         START=1, LEN=0  -> stay in IDLE, pulse DONE=1 on the next cycle, no pops.
//   RUN:  lasts until the final issue cycle, then returns to IDLE.
//  Step counter t has width LEN_W+ROWS_LOG2; it counts 0 .. len_q+ROWS-2.
//  In RUN, for each row r: due_r = (t >= r) && (t - r < len_q). Compare at full width; no wrap.
//  Stall: stall = |(due & FIFO_EMPTY).
//   - POPE = stall ? 0 : due. POPE is combinational and must respond to FIFO_EMPTY in the same cycle.
//  Counter update: t increments only when !stall, so a stall freezes every row.
//  Completion: in the cycle where t == len_q+ROWS-2 and !stall, that issue occurs and the next state is IDLE.
//   DONE=1 in the following cycle only. BUSY=1 exactly while in RUN.
//  ABORT in RUN: POPE=0 in that cycle, next state is IDLE, no DONE pulse. ABORT in IDLE is ignored.
//  START while in RUN: ignored; LEN is not resampled.
//  Reset mid-tile: immediate return to IDLE. FIFO contents are the loader's responsibility.
//  Latency: START at cycle 0 -> first POPE (row 0) at cycle 1.
//   With no stalls, the last POPE (row ROWS-1) is at cycle len_q+ROWS-1 and DONE at cycle len_q+ROWS.
// CONFIGURATION
//  Macro FEED_STALL_CNT_EN
//   defined: STALL_CNT is cleared when a START is accepted, then increments on every RUN cycle with
//            stall=1. It saturates at all-ones and holds its value after the tile ends.
//   undefined: no counter logic is built; STALL_CNT is tied to 0.
// STRUCTURE
//  Shared package feed_pkg: state encoding (FEED_IDLE=1'b0, FEED_RUN=1'b1) and default ROWS/LEN_W constants.
//  One sub-module, feed_row_mask: combinational (t, len_q) -> due[ROWS].
//  Everything else is flat: FSM, counter, stall logic and the optional counter.
// TESTING
//  ROWS=4, LEN=4, all FIFOs non-empty, START at cycle 0
//   -> POPE for cycles 1..7 = 0001,0011,0111,1111,1110,1100,1000; DONE=1 at cycle 8 only.
//  Same as above, but FIFO_EMPTY[2]=1 during cycles 3..5
//   -> POPE=0000 in cycles 3..5; pattern resumes 0111 at cycle 6; DONE at cycle 11; STALL_CNT=3 (macro on).
//  ABORT at cycle 4 of the first test -> POPE=0000 at cycle 4; BUSY=0 from cycle 5; DONE never pulses.
//  START with LEN=0 -> DONE pulses on the next cycle; POPE stays 0; BUSY stays 0.
//  START again at cycle 3 of a tile with a different LEN
//   -> ignored; the original pattern completes unchanged.
//  RSTn low at cycle 3 -> POPE=0 and BUSY=0 immediately; after release a new START runs normally.
//  Macro off -> STALL_CNT==0 throughout the stall test.

Source files
------------

// File: rtl/feed_pkg.sv
// Shared definitions for the systolic feed controller: state encoding and default sizes.
package feed_pkg;
  typedef enum logic {
    FEED_IDLE = 1'b0,
    FEED_RUN  = 1'b1
  } feed_state_e;

  localparam int FEED_ROWS      = 32;
  localparam int FEED_ROWS_LOG2 = 5;
  localparam int FEED_LEN_W     = 8;
  localparam int FEED_SCNT_W    = 16;
endpackage

// File: rtl/systolic_feed_ctrl_if.sv
// Control/status bundle between the operand loader, the row FIFOs and the feed controller.
interface systolic_feed_ctrl_if
  import feed_pkg::*;
#(
  parameter int ROWS   = FEED_ROWS,
  parameter int LEN_W  = FEED_LEN_W,
  parameter int SCNT_W = FEED_SCNT_W
);
  logic              START;
  logic [LEN_W-1:0]  LEN;
  logic              ABORT;
  logic [ROWS-1:0]   FIFO_EMPTY;
  logic [ROWS-1:0]   POPE;
  logic              BUSY;
  logic              DONE;
  logic [SCNT_W-1:0] STALL_CNT;

  modport master (output START, LEN, ABORT, FIFO_EMPTY,
                  input  POPE, BUSY, DONE, STALL_CNT);
  modport slave  (input  START, LEN, ABORT, FIFO_EMPTY,
                  output POPE, BUSY, DONE, STALL_CNT);
endinterface

// File: rtl/feed_row_mask.sv
// Diagonal wavefront mask: row r is due while step t lies in [r, r+len_q).
module feed_row_mask #(
  parameter int ROWS  = 32,
  parameter int LEN_W = 8,
  parameter int T_W   = 13
) (
  input  logic [T_W-1:0]   t,
  input  logic [LEN_W-1:0] len_q,
  output logic [ROWS-1:0]  due
);
  logic [T_W-1:0] len_x;
  assign len_x = T_W'(len_q);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    localparam logic [T_W-1:0] R = T_W'(r);
    // Guard t>=R first so the subtraction never wraps.
    assign due[r] = (t >= R) && ((t - R) < len_x);
  end
endmodule

// File: rtl/systolic_feed_ctrl.sv
// Skewed pop scheduler for the PE-array row FIFOs; all rows stall together on any due-empty row.
// Optional stall counter built when FEED_STALL_CNT_EN is defined.
module systolic_feed_ctrl
  import feed_pkg::*;
#(
  parameter int ROWS      = FEED_ROWS,
  parameter int ROWS_LOG2 = FEED_ROWS_LOG2,
  parameter int LEN_W     = FEED_LEN_W,
  parameter int SCNT_W    = FEED_SCNT_W
) (
  input logic               CLK,
  input logic               RSTn,
  systolic_feed_ctrl_if.slave bus
);
  localparam int T_W = LEN_W + ROWS_LOG2;

  feed_state_e      state, state_nxt;
  logic [T_W-1:0]   t, t_nxt;
  logic [LEN_W-1:0] len_q, len_nxt;
  logic             done_q, done_nxt;
  logic [ROWS-1:0]  due, pope;
  logic             run, stall, last;

  feed_row_mask #(.ROWS(ROWS), .LEN_W(LEN_W), .T_W(T_W)) u_mask (
    .t     (t),
    .len_q (len_q),
    .due   (due)
  );

  assign run   = (state == FEED_RUN);
  assign stall = run && |(due & bus.FIFO_EMPTY);
  assign last  = (t == (T_W'(len_q) + T_W'(ROWS - 2)));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state  <= FEED_IDLE;
      t      <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      t      <= t_nxt;
      len_q  <= len_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    len_nxt   = len_q;
    done_nxt  = 1'b0;
    pope      = '0;
    case (state)
      FEED_IDLE: begin
        if (bus.START) begin
          if (bus.LEN != '0) begin
            state_nxt = FEED_RUN;
            len_nxt   = bus.LEN;
            t_nxt     = '0;
          end else begin
            done_nxt  = 1'b1;
          end
        end
      end
      FEED_RUN: begin
        if (bus.ABORT) begin
          state_nxt = FEED_IDLE;
          t_nxt     = '0;
        end else if (!stall) begin
          pope = due;
          if (last) begin
            state_nxt = FEED_IDLE;
            done_nxt  = 1'b1;
            t_nxt     = '0;
          end else begin
            t_nxt = t + 1'b1;
          end
        end
      end
      default: state_nxt = FEED_IDLE;
    endcase
  end

  assign bus.POPE = pope;
  assign bus.BUSY = run;
  assign bus.DONE = done_q;

`ifdef FEED_STALL_CNT_EN
  logic [SCNT_W-1:0] scnt;

  // Cleared on any START seen in IDLE; saturates and holds after the tile.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                              scnt <= '0;
    else if (!run && bus.START)             scnt <= '0;
    else if (stall && (scnt != '1))         scnt <= scnt + 1'b1;
  end

  assign bus.STALL_CNT = scnt;
`else
  assign bus.STALL_CNT = '0;
`endif
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl: directed spec scenarios followed by random traffic.
module tb_systolic_feed_ctrl;
  localparam int ROWS = 4, ROWS_LOG2 = 2, LEN_W = 4, SCNT_W = 16;
  localparam int SCNT_MAX = (1 << SCNT_W) - 1;

  logic CLK = 1'b0;
  logic RSTn;
  always #5 CLK = ~CLK;

  systolic_feed_ctrl_if #(.ROWS(ROWS), .LEN_W(LEN_W), .SCNT_W(SCNT_W)) bus ();

  systolic_feed_ctrl #(.ROWS(ROWS), .ROWS_LOG2(ROWS_LOG2), .LEN_W(LEN_W), .SCNT_W(SCNT_W)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  typedef struct {
    logic [ROWS-1:0]   pope;
    logic              busy;
    logic              done;
    logic [SCNT_W-1:0] scnt;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Reference model: a tile is a window of steps; row r pops at steps r .. r+len-1.
  bit m_busy, m_done;
  int m_step, m_len, m_scnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit rstn, input bit start, input int len, input bit abort,
                     input logic [ROWS-1:0] empty);
    exp_t e;
    bit stall;
    logic [ROWS-1:0] due;
    @(posedge CLK); #1;
    RSTn           = rstn;
    bus.START      = start;
    bus.LEN        = LEN_W'(len);
    bus.ABORT      = abort;
    bus.FIFO_EMPTY = empty;
    if (!rstn) begin
      m_busy = 0; m_done = 0; m_step = 0; m_len = 0; m_scnt = 0;
      e.pope = '0; e.busy = 1'b0; e.done = 1'b0; e.scnt = '0;
    end else begin
      due = '0;
      for (int r = 0; r < ROWS; r++)
        if (m_busy && m_step >= r && m_step < r + m_len) due[r] = 1'b1;
      stall  = |(due & empty);
      e.pope = (stall || abort) ? '0 : due;
      e.busy = m_busy;
      e.done = m_done;
`ifdef FEED_STALL_CNT_EN
      e.scnt = SCNT_W'(m_scnt);
`else
      e.scnt = '0;
`endif
      if (!m_busy) begin
        m_done = start && (len == 0);
        if (start) m_scnt = 0;
        if (start && len > 0) begin
          m_busy = 1; m_step = 0; m_len = len;
        end
      end else begin
        m_done = 0;
        if (stall && m_scnt < SCNT_MAX) m_scnt++;
        if (abort) m_busy = 0;
        else if (!stall) begin
          if (m_step == m_len + ROWS - 2) begin
            m_busy = 0; m_done = 1;
          end else m_step++;
        end
      end
    end
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("POPE",      int'(bus.POPE),      int'(e.pope));
        chk("BUSY",      int'(bus.BUSY),      int'(e.busy));
        chk("DONE",      int'(bus.DONE),      int'(e.done));
        chk("STALL_CNT", int'(bus.STALL_CNT), int'(e.scnt));
      end
    end
  end

  initial begin : stim
    RSTn = 1'b0; bus.START = 1'b0; bus.LEN = '0; bus.ABORT = 1'b0; bus.FIFO_EMPTY = '0;
    cyc(0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, '0);
    idle(2);

    // Plain tile, no stalls.
    cyc(1, 1, 4, 0, '0);
    idle(10);

    // Row 2 empty during cycles 3..5 of the tile.
    cyc(1, 1, 4, 0, '0);
    for (int c = 1; c <= 12; c++)
      cyc(1, 0, 0, 0, (c >= 3 && c <= 5) ? 4'b0100 : 4'b0000);
    idle(2);

    // Abort at cycle 4.
    cyc(1, 1, 4, 0, '0);
    for (int c = 1; c <= 8; c++) cyc(1, 0, 0, (c == 4), '0);

    // Zero-length tile.
    cyc(1, 1, 0, 0, '0);
    idle(3);

    // Second START mid-tile with a different LEN is ignored.
    cyc(1, 1, 4, 0, '0);
    for (int c = 1; c <= 10; c++) cyc(1, (c == 3), 7, 0, '0);

    // Reset mid-tile, then a fresh tile.
    cyc(1, 1, 4, 0, '0);
    idle(2);
    cyc(0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, '0);
    cyc(1, 1, 3, 0, '0);
    idle(8);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [ROWS-1:0] em;
      for (int r = 0; r < ROWS; r++) em[r] = ($urandom_range(0, 5) == 0);
      cyc(($urandom_range(0, 499) != 0),
          ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 9)),
          ($urandom_range(0, 39) == 0),
          em);
    end

    repeat (3) @(posedge CLK);
    if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
